// File: rtl/jk_seq_driver.sv
// jk_seq_driver: drives an external JK flip-flop bank to a requested target word.
// The target is accepted on valid/ready. Each attempt is drive, settle, then verify, with bounded retries.
module jk_seq_driver #(
    parameter int WIDTH      = 4,
    parameter int SETTLE_CYC = 1,
    parameter int MAX_RETRY  = 2
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic [WIDTH-1:0] tgt,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             done,
    output logic             err,
    output logic             err_flag,
    output logic [2:0]       retries
);
    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;
    state_t           state;
    logic [WIDTH-1:0] tgt_q;
    logic [3:0]       cnt;
    assign tgt_ready = (state == IDLE) && !Resetn;
    always_ff @(posedge Clk or posedge Resetn) begin
        if (Resetn) begin
            state    <= IDLE;
            J        <= '0;
            K        <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_flag <= 1'b0;
            retries  <= '0;
            tgt_q    <= '0;
            cnt      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: if (tgt_valid) begin
                    tgt_q    <= tgt;
                    retries  <= '0;
                    err_flag <= 1'b0;
                    J        <= ~q_fb & tgt;
                    K        <= q_fb & ~tgt;
                    state    <= DRIVE;
                end
                DRIVE: begin
                    J     <= '0;
                    K     <= '0;
                    cnt   <= 4'(SETTLE_CYC - 1);
                    state <= SETTLE;
                end
                SETTLE: if (cnt == 4'd0) state <= CHECK; else cnt <= cnt - 4'd1;
                CHECK: if (q_fb == tgt_q) begin
                    done  <= 1'b1;
                    state <= IDLE;
                end else if (retries < 3'(MAX_RETRY)) begin
                    // Re-excite from the bank's present Q, so only wrong bits are driven again
                    retries <= retries + 3'd1;
                    J       <= ~q_fb & tgt_q;
                    K       <= q_fb & ~tgt_q;
                    state   <= DRIVE;
                end else begin
                    err      <= 1'b1;
                    err_flag <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jk_seq_driver.sv
// tb_jk_seq_driver: JK bank model with fault injection, plus an attempt-level reference model.
module tb_jk_seq_driver;
    localparam int S  = 1;
    localparam int MR = 2;
    localparam int P  = 2 + S;

    logic       Clk = 1'b0;
    logic       Resetn;
    logic [3:0] tgt;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] q_fb;
    logic [3:0] J;
    logic [3:0] K;
    logic       done;
    logic       err;
    logic       err_flag;
    logic [2:0] retries;

    int n = 0;
    int errs = 0;

    logic [3:0] bq;
    logic       ld = 1'b0;
    logic [3:0] ld_val = '0;
    int         drv2 = 0;
    bit         stuck0 = 0;
    bit         trans2 = 0;
    bit         trans_used = 0;
    logic [3:0] ref_q;

    jk_seq_driver #(.WIDTH(4), .SETTLE_CYC(S), .MAX_RETRY(MR)) dut (
        .Clk(Clk), .Resetn(Resetn), .tgt(tgt), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
        .q_fb(q_fb), .J(J), .K(K), .done(done), .err(err), .err_flag(err_flag), .retries(retries)
    );

    always #5 Clk = ~Clk;
    assign q_fb = bq;

    // External JK bank: bit0 may be stuck at 0, bit2 may ignore its first drive
    always @(posedge Clk) begin
        logic [3:0] nq;
        if (ld) begin
            bq   <= ld_val;
            drv2 <= 0;
        end else begin
            nq = (bq & ~K) | (~bq & J);
            if (stuck0) nq[0] = 1'b0;
            if (J[2] | K[2]) begin
                drv2 <= drv2 + 1;
                if (trans2 && drv2 == 0) nq[2] = bq[2];
            end
            bq <= nq;
        end
    end

    task automatic load_q(input logic [3:0] v);
        @(negedge Clk);
        ld = 1'b1;
        ld_val = v;
        @(posedge Clk);
        #1 ld = 1'b0;
        ref_q = v;
    endtask

    task automatic xfer(input logic [3:0] t);
        int w = 0;
        @(negedge Clk);
        tgt = t;
        tgt_valid = 1'b1;
        while (tgt_ready !== 1'b1 && w < 50) begin
            @(negedge Clk);
            w++;
        end
        n++;
        if (tgt_ready !== 1'b1) begin
            errs++;
            $display("FAIL xfer_ready got=%b exp=1", tgt_ready);
        end
        @(posedge Clk);
        #1 tgt_valid = 1'b0;
        tgt = 4'($urandom);
    endtask

    task automatic run_op(input logic [3:0] t, input string name);
        logic [3:0] ej[8];
        logic [3:0] ek[8];
        logic [3:0] qb;
        logic [3:0] qa;
        logic [3:0] xj;
        logic [3:0] xk;
        int att = 0;
        bit ok = 0;
        int last;
        qb = ref_q;
        qa = qb;
        // Each attempt aims the bank at t; faulty bits deviate from it
        while (1) begin
            ej[att] = t & ~qb;
            ek[att] = ~t & qb;
            qa = t;
            if (stuck0) qa[0] = 1'b0;
            if (trans2 && !trans_used && t[2] != qb[2]) begin
                qa[2] = qb[2];
                trans_used = 1;
            end
            att++;
            qb = qa;
            if (qa == t) begin
                ok = 1;
                break;
            end
            if (att == MR + 1) break;
        end
        ref_q = qa;
        last = att * P;
        xfer(t);
        for (int c = 0; c <= last; c++) begin
            @(negedge Clk);
            xj = (c % P == 0 && c / P < att) ? ej[c / P] : 4'b0000;
            xk = (c % P == 0 && c / P < att) ? ek[c / P] : 4'b0000;
            n++;
            if (J !== xj || K !== xk) begin
                errs++;
                $display("FAIL %s_jk c=%0d got J=%b K=%b exp J=%b K=%b", name, c, J, K, xj, xk);
            end
            n++;
            if (done !== (ok && c == last) || err !== (!ok && c == last)) begin
                errs++;
                $display("FAIL %s_pulse c=%0d got done=%b err=%b exp done=%b err=%b", name, c, done,
                         err, ok && c == last, !ok && c == last);
            end
            if (c == 0) begin
                n++;
                if (err_flag !== 1'b0) begin
                    errs++;
                    $display("FAIL %s_flag_clear got=%b exp=0", name, err_flag);
                end
            end
        end
        n++;
        if (retries !== 3'(att - 1) || err_flag !== !ok || tgt_ready !== 1'b1) begin
            errs++;
            $display("FAIL %s_end got retries=%0d flag=%b ready=%b exp retries=%0d flag=%b ready=1",
                     name, retries, err_flag, tgt_ready, att - 1, !ok);
        end
        n++;
        if (bq !== ref_q) begin
            errs++;
            $display("FAIL %s_q got=%b exp=%b", name, bq, ref_q);
        end
        @(negedge Clk);
        n++;
        if (done !== 1'b0 || err !== 1'b0 || retries !== 3'(att - 1)) begin
            errs++;
            $display("FAIL %s_after got done=%b err=%b retries=%0d exp 0 0 %0d", name, done, err,
                     retries, att - 1);
        end
    endtask

    task automatic test_reset;
        Resetn = 1'b1;
        tgt_valid = 1'b1;
        tgt = 4'b1111;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        n++;
        if (tgt_ready !== 1'b0 || J !== 4'b0 || K !== 4'b0 || done !== 1'b0 || err !== 1'b0 ||
            err_flag !== 1'b0 || retries !== 3'd0) begin
            errs++;
            $display("FAIL reset got ready=%b J=%b K=%b done=%b err=%b flag=%b retries=%0d exp all 0",
                     tgt_ready, J, K, done, err, err_flag, retries);
        end
        tgt_valid = 1'b0;
        Resetn = 1'b0;
        #1;
        n++;
        if (tgt_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_release_ready got=%b exp=1", tgt_ready);
        end
    endtask

    task automatic test_basic;
        load_q(4'b0000);
        run_op(4'b1010, "basic");
    endtask

    task automatic test_mixed;
        load_q(4'b1100);
        run_op(4'b1010, "mixed");
        run_op(4'b1010, "same");
    endtask

    task automatic test_stuck;
        stuck0 = 1;
        load_q(4'b0000);
        run_op(4'b0001, "stuck");
        run_op(4'b0000, "stuck_clear");
        stuck0 = 0;
    endtask

    task automatic test_transient;
        trans2 = 1;
        trans_used = 0;
        load_q(4'b0000);
        run_op(4'b0100, "transient");
        trans2 = 0;
    endtask

    task automatic test_mid_reset;
        load_q(4'b0000);
        xfer(4'b0110);
        @(negedge Clk);
        @(negedge Clk);
        #2 Resetn = 1'b1;
        #1;
        n++;
        if (J !== 4'b0 || K !== 4'b0 || done !== 1'b0 || err !== 1'b0 || tgt_ready !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset got J=%b K=%b done=%b err=%b ready=%b exp 0", J, K, done, err,
                     tgt_ready);
        end
        @(negedge Clk);
        Resetn = 1'b0;
        #1;
        ref_q = 4'b0110;
        n++;
        if (tgt_ready !== 1'b1 || bq !== ref_q) begin
            errs++;
            $display("FAIL mid_reset_idle got ready=%b q=%b exp ready=1 q=%b", tgt_ready, bq, ref_q);
        end
        run_op(4'b0011, "post_reset");
    endtask

    task automatic test_random;
        for (int i = 0; i < 12; i++) begin
            load_q(4'($urandom));
            run_op(4'($urandom), "random");
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 6; i++) run_op(4'($urandom), "b2b");
    endtask

    initial begin
        test_reset;
        test_basic;
        test_mixed;
        test_stuck;
        test_transient;
        test_mid_reset;
        test_random;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n, errs);
        $finish;
    end
endmodule
